// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core types, widths and address helpers
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int DMEM_DEPTH = 256;

  typedef logic [31:0] word_t;

  // Byte address to word index; upper bits beyond the memory depth are dropped (wrap).
  function automatic word_t word_index(input word_t addr, input int unsigned depth);
    return (addr >> 2) & word_t'(depth - 1);
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - MEM-stage data memory access bundle
interface data_mem_if #(
  parameter int DATA_W = 32
);

  logic              WE;
  logic              memread;
  logic [31:0]       A;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] RD;

  modport master (output WE, output memread, output A, output WD, input RD);
  modport slave  (input WE, input memread, input A, input WD, output RD);

endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory, synchronous write, combinational gated read
module data_mem
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;

  assign idx = ADDR_W'(word_index(bus.A, DEPTH));

  // Reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.WE) begin
      mem[idx] <= bus.WD;
    end
  end

  assign bus.RD = bus.memread ? mem[idx] : '0;

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - randomized self-checking bench for data_mem against a behavioural model
module tb_data_mem;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_mem_if #(.DATA_W(32)) bus ();

  data_mem dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] model [256];
  bit          model_ok = 1'b0;
  int          vectors  = 0;
  int          errors   = 0;

  // Reference: byte address / 4, modulo 256 words.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) model[i] <= 32'd0;
      model_ok <= 1'b1;
    end else if (bus.WE && model_ok) begin
      model[(bus.A / 4) % 256] <= bus.WD;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      vectors++;
      if (bus.RD !== (bus.memread ? model[(bus.A / 4) % 256] : 32'd0)) begin
        errors++;
        $display("FAIL cycle_check t=%0t A=%h memread=%b WE=%b RD=%h expected=%h", $time, bus.A,
                 bus.memread, bus.WE, bus.RD, bus.memread ? model[(bus.A / 4) % 256] : 32'd0);
      end
    end
  end

  task automatic drive(input logic r, input logic we, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst         = r;
    bus.WE      = we;
    bus.memread = rd;
    bus.A       = a;
    bus.WD      = wd;
  endtask

  task automatic lit(input string name, input logic [31:0] expected);
    @(negedge clk);
    #1;
    vectors++;
    if (bus.RD !== expected) begin
      errors++;
      $display("FAIL %s RD=%0d expected=%0d", name, bus.RD, expected);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.WE      = 1'b0;
    bus.memread = 1'b0;
    bus.A       = 32'd0;
    bus.WD      = 32'd0;

    drive(0, 0, 1, 32'd0, 32'd0);
    lit("reset_a0", 32'd0);
    drive(0, 0, 1, 32'd1020, 32'd0);
    lit("reset_last_word", 32'd0);

    drive(0, 1, 0, 32'd50, 32'd12345);
    drive(0, 0, 1, 32'd50, 32'd0);
    lit("readback_50", 32'd12345);
    drive(0, 0, 1, 32'd48, 32'd0);
    lit("alias_48", 32'd12345);

    drive(0, 1, 0, 32'd100, 32'd67890);
    drive(0, 0, 1, 32'd100, 32'd0);
    lit("readback_100", 32'd67890);
    drive(0, 0, 1, 32'd50, 32'd0);
    lit("no_cross_50", 32'd12345);

    drive(0, 0, 0, 32'd100, 32'd0);
    lit("gated_100", 32'd0);
    drive(0, 0, 1, 32'd1124, 32'd0);
    lit("wrap_1124", 32'd67890);

    drive(0, 1, 1, 32'd200, 32'd7);
    lit("rw_before_edge", 32'd0);
    lit("rw_after_edge", 32'd7);

    drive(1, 1, 0, 32'd50, 32'd99);
    drive(0, 0, 1, 32'd50, 32'd0);
    lit("rst_priority_50", 32'd0);
    drive(0, 0, 1, 32'd100, 32'd0);
    lit("rst_priority_100", 32'd0);

    for (int n = 0; n < 2000; n++) begin
      drive(($urandom % 64) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0, $urandom, $urandom);
    end
    drive(0, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
